// File: rtl/mux8_to_1.sv
// mux8_to_1: 8-to-1 bit selector built from gate-level 2:1 and 4:1 stages, with a registered copy
module mux2_to_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic out
);
    logic s_n;
    logic pick_a;
    logic pick_b;
    not g_inv (s_n, s);
    and g_a (pick_a, a, s_n);
    and g_b (pick_b, b, s);
    or  g_or (out, pick_a, pick_b);
endmodule

// mux4_to_1: two 2:1 stages on sel[0], then a 2:1 on sel[1]
module mux4_to_1 (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);
    logic lo;
    logic hi;
    mux2_to_1 u_lo  (.a(in[0]), .b(in[1]), .s(sel[0]), .out(lo));
    mux2_to_1 u_hi  (.a(in[2]), .b(in[3]), .s(sel[0]), .out(hi));
    mux2_to_1 u_fin (.a(lo),    .b(hi),    .s(sel[1]), .out(out));
endmodule

// mux32_to_1: four 8:1 leaves on byte lanes feeding a 4:1 root on sel[4:3]
module mux32_to_1 (
    input  logic [31:0] in,
    input  logic [4:0]  sel,
    output logic        out
);
    logic [3:0] leaf;
    for (genvar k = 0; k < 4; k++) begin : g_leaf
        mux8_to_1 u_leaf (
            .clk  (1'b0),
            .reset(1'b0),
            .in   (in[8*k+7:8*k]),
            .sel  (sel[2:0]),
            .out  (leaf[k]),
            .out_q()
        );
    end
    mux4_to_1 u_root (.in(leaf), .sel(sel[4:3]), .out(out));
endmodule

module mux8_to_1 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out,
    output logic       out_q
);
    logic lower;
    logic upper;
    mux4_to_1 u_lower (.in(in[3:0]), .sel(sel[1:0]), .out(lower));
    mux4_to_1 u_upper (.in(in[7:4]), .sel(sel[1:0]), .out(upper));
    mux2_to_1 u_final (.a(lower), .b(upper), .s(sel[2]), .out(out));
    // capture the selected bit each rising edge; reset clears it without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= 1'b0;
        else       out_q <= out;
    end
endmodule

// File: tb/tb_mux8_to_1.sv
// tb_mux8_to_1: table-driven check of the 8:1 selector, its 4:1 stage, the 32:1 cascade and the registered output
module tb_mux8_to_1;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in = 8'h00;
    logic [2:0]  sel = 3'd0;
    logic        out;
    logic        out_q;
    logic [3:0]  in4 = 4'h0;
    logic [1:0]  sel4 = 2'd0;
    logic        out4;
    logic [31:0] in32 = 32'h0;
    logic [4:0]  sel32 = 5'd0;
    logic        out32;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] in;
        logic [2:0] sel;
        logic       exp;
    } vec_t;

    mux8_to_1 dut (.clk(clk), .reset(reset), .in(in), .sel(sel), .out(out), .out_q(out_q));
    mux4_to_1 u_m4 (.in(in4), .sel(sel4), .out(out4));
    mux32_to_1 u_m32 (.in(in32), .sel(sel32), .out(out32));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    initial begin
        vec_t hand [8];
        logic [7:0]  p8 [5];
        logic [3:0]  p4 [5];
        logic [31:0] p32 [5];
        logic [7:0]  tmp8;
        logic [3:0]  tmp4;
        logic [31:0] tmp32;
        hand[0] = '{8'h55, 3'd3, 1'b0};
        hand[1] = '{8'hAA, 3'd3, 1'b1};
        hand[2] = '{8'hF0, 3'd7, 1'b1};
        hand[3] = '{8'h0F, 3'd0, 1'b1};
        hand[4] = '{8'h0F, 3'd4, 1'b0};
        hand[5] = '{8'hF0, 3'd3, 1'b0};
        hand[6] = '{8'h55, 3'd6, 1'b1};
        hand[7] = '{8'hAA, 3'd0, 1'b0};
        p8  = '{8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        p4  = '{4'h0, 4'h5, 4'hA, 4'h3, 4'hC};
        p32 = '{32'h00000000, 32'h55555555, 32'hAAAAAAAA, 32'h0000FFFF, 32'hFFFF0000};

        #1;
        chk("reset_out_q", out_q, 1'b0);

        for (int i = 0; i < 8; i++) begin
            in = hand[i].in;
            sel = hand[i].sel;
            #10;
            chk($sformatf("hand[%0d] in=%h sel=%0d", i, in, sel), out, hand[i].exp);
        end

        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < 5; p++) begin
                tmp8 = p8[p];
                in = tmp8;
                sel = 3'(s);
                #10;
                chk($sformatf("walk8 in=%h sel=%0d", tmp8, s), out, tmp8[s]);
            end
        end
        chk("out_q_held_in_reset", out_q, 1'b0);

        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 5; p++) begin
                tmp4 = p4[p];
                in4 = tmp4;
                sel4 = 2'(s);
                #10;
                chk($sformatf("walk4 in=%h sel=%0d", tmp4, s), out4, tmp4[s]);
            end
        end
        in4 = 4'h5; sel4 = 2'd2; #10;
        chk("m4 sel=2 in=5", out4, 1'b1);

        for (int s = 0; s < 32; s++) begin
            for (int p = 0; p < 5; p++) begin
                tmp32 = p32[p];
                in32 = tmp32;
                sel32 = 5'(s);
                #10;
                chk($sformatf("walk32 in=%h sel=%0d", tmp32, s), out32, tmp32[s]);
            end
        end
        in32 = 32'h0000FFFF; sel32 = 5'd16; #10;
        chk("m32 sel=16", out32, 1'b0);
        sel32 = 5'd15; #10;
        chk("m32 sel=15", out32, 1'b1);

        in = 8'bxxxxxxx1; sel = 3'd0; #10;
        chk("isolation", out, 1'b1);

        @(negedge clk);
        reset = 1'b0;
        in = 8'h80;
        sel = 3'd7;
        #1;
        chk("reg out comb", out, 1'b1);
        chk("reg out_q before edge", out_q, 1'b0);
        @(posedge clk); #1;
        chk("reg out_q after edge", out_q, 1'b1);
        sel = 3'd0; #1;
        chk("sel0 out", out, 1'b0);
        chk("sel0 out_q holds", out_q, 1'b1);
        @(posedge clk); #1;
        chk("sel0 out_q next edge", out_q, 1'b0);
        sel = 3'd7;
        @(posedge clk); #1;
        chk("sel7 out_q", out_q, 1'b1);

        @(negedge clk);
        reset = 1'b1; #1;
        chk("async reset out_q", out_q, 1'b0);
        chk("async reset out", out, 1'b1);
        #1 reset = 1'b0; #1;
        chk("after release before edge", out_q, 1'b0);
        @(posedge clk); #1;
        chk("restore out_q", out_q, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
